mmc_cmd_control_layer_init_seq: RTL and testbench
=================================================

# mmc_cmd_control_layer_init_seq

Parametrised MMC/SD SPI-mode power-up sequencer that sits between the MMC controller's init control and the byte-level SPI transfer layer. It sends a configurable run of 0xFF clock bytes with chip-select deasserted. It can then issue CMD0 (GO_IDLE_STATE) with CS asserted, poll for the R1 response and retry on failure. It reports completion and pass/fail to the controller.

## Interface
- P_DUMMY_BYTES, 10, number of 0xFF bytes sent with CS high (1..255).
- P_RESP_POLL, 8, maximum 0xFF poll bytes per CMD0 attempt while waiting for R1 (1..255).
- P_RETRY, 3, additional CMD0 attempts after the first (0..15).

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  asynchronous, active-low reset.
- iINIT_START  in  1  start pulse; honoured only in IDLE.
- oINIT_BUSY  out  1  high in every state except IDLE.
- oINIT_END  out  1  one-cycle completion pulse.
- oINIT_ERROR  out  1  result flag; valid from oINIT_END until the next accepted start.
- oMMC_REQ  out  1  byte transfer request; a byte is accepted in any cycle where oMMC_REQ=1.
- iMMC_BUSY  in  1  byte layer busy.
- oMMC_CS  out  1  CS line level (1 = deselected).
- oMMC_DATA  out  8  byte to transmit.
- iMMC_VALID  in  1  one-cycle pulse: received byte valid.
- iMMC_DATA  in  8  received byte.

## Operation
- States: IDLE, DUMMY, DUMMY_WAIT, CMD, POLL_REQ, POLL_WAIT, TRAIL, END.
- IDLE: on iINIT_START go to DUMMY, clear all counters and oINIT_ERROR.
- DUMMY: oMMC_DATA=0xFF, CS=1. Each accept increments the byte count. After P_DUMMY_BYTES accepts, go to DUMMY_WAIT.
- DUMMY_WAIT: no request. When !iMMC_BUSY, go to CMD (macro set) or END (macro clear).
- CMD: CS=0. Send frame bytes 0x40,0x00,0x00,0x00,0x00,0x95 in order, one per accept. After the 6th accept, go to POLL_REQ with the poll count cleared.
- POLL_REQ: CS=0, data 0xFF. On accept, increment the poll count and go to POLL_WAIT.
- POLL_WAIT: no request. On iMMC_VALID:
  - iMMC_DATA==0x01: success, go to TRAIL.
  - iMMC_DATA==0xFF and poll count < P_RESP_POLL: go to POLL_REQ.
  - Otherwise (bad R1 or poll budget exhausted): the attempt fails.
- Failed attempt:
  - Retry count < P_RETRY: increment retry count, go to CMD.
  - Retry count = P_RETRY: set oINIT_ERROR, go to TRAIL.
- TRAIL: CS=1, data 0xFF. One accept, then wait for !iMMC_BUSY, then go to END.
- END: oINIT_END=1 for one cycle, then IDLE.
- Idle data/CS outside the active states: oMMC_DATA=0xFF, oMMC_CS=1.
- Ignored events:
  - iMMC_VALID outside POLL_WAIT.
  - iINIT_START outside IDLE.
- Counter widths: byte/poll counters 8 bits; retry counter 4 bits; CMD index 3 bits.
- No counter wraps, because all limits are checked before the increment.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - oINIT_ERROR=0, oINIT_END=0, oINIT_BUSY=0, oMMC_REQ=0.
  - oMMC_CS=1, oMMC_DATA=0xFF.
- oMMC_REQ = !iMMC_BUSY && state∈{DUMMY, CMD, POLL_REQ, TRAIL}. It is combinational, so a request can be accepted on the same cycle iMMC_BUSY falls.
- oMMC_CS and oMMC_DATA are decoded from registered state and counters, so they are stable throughout an accept cycle.
- IDLE→DUMMY takes one cycle after start. With iMMC_BUSY held low, DUMMY accepts one byte per cycle.
- Retry: a failed attempt reaches CMD on the cycle after iMMC_VALID, and CS stays 0 across the retry.
- Reset mid-operation: returns to IDLE immediately and CS drives 1 immediately (asynchronous). No END pulse is produced.

## Configuration
- MMC_INIT_CMD0_EN defined: the full sequence above is compiled in.
- MMC_INIT_CMD0_EN undefined:
  - CMD/POLL/TRAIL logic and the retry/poll counters are compiled out.
  - DUMMY_WAIT goes straight to END; oINIT_ERROR is tied to 0.
  - iMMC_VALID and iMMC_DATA are unused.
  - CS is constantly 1 and data is constantly 0xFF.

## Structure
- Shared package mmc_init_pkg holds:
  - State encoding localparams.
  - CMD0 frame byte constants and the R1 idle value 0x01.
  - The 0xFF idle-byte constant.
- Sub-module mmc_init_frame_rom: combinational 3-bit index → 8-bit CMD0 frame byte.

## Test plan
- Macro off, P_DUMMY_BYTES=10, BUSY low: start → exactly 10 accepts of 0xFF with CS=1, then END pulse, ERROR=0.
- Macro on, card returns 0xFF,0xFF,0x01:
  - 10 dummy bytes with CS=1.
  - 6-byte frame 40 00 00 00 00 95 with CS=0.
  - 3 poll accepts, then 1 trail byte with CS=1.
  - END with ERROR=0.
- Macro on, P_RESP_POLL=8, P_RETRY=3, card always 0xFF: 4 CMD frames with 8 polls each, then trail, END with ERROR=1.
- Macro on, first attempt returns 0x05, second returns 0x01: exactly 2 CMD frames, ERROR=0.
- BUSY toggled randomly: byte sequence unchanged, and no accept occurs while iMMC_BUSY=1.
- inRESET asserted during the CMD frame: CS=1, REQ=0 and state IDLE immediately. The next start begins cleanly from DUMMY.

Source files
------------

// File: rtl/mmc_init_pkg.sv
// ----------------------------------------------------------------------------
// mmc_init_pkg
// Shared definitions for the MMC/SD SPI-mode power-up sequencer:
//   - state encodings and the state enum
//   - CMD0 (GO_IDLE_STATE) frame bytes and the R1 "idle" response value
//   - the 0xFF byte driven whenever the bus is idle
// ----------------------------------------------------------------------------
package mmc_init_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DUMMY      = 3'd1;
  localparam logic [2:0] ST_DUMMY_WAIT = 3'd2;
  localparam logic [2:0] ST_CMD        = 3'd3;
  localparam logic [2:0] ST_POLL_REQ   = 3'd4;
  localparam logic [2:0] ST_POLL_WAIT  = 3'd5;
  localparam logic [2:0] ST_TRAIL      = 3'd6;
  localparam logic [2:0] ST_END        = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_DUMMY      = ST_DUMMY,
    S_DUMMY_WAIT = ST_DUMMY_WAIT,
    S_CMD        = ST_CMD,
    S_POLL_REQ   = ST_POLL_REQ,
    S_POLL_WAIT  = ST_POLL_WAIT,
    S_TRAIL      = ST_TRAIL,
    S_END        = ST_END
  } state_t;

  // CMD0 frame: start bits + index, 32-bit zero argument, CRC7 + end bit
  localparam logic [7:0] CMD0_BYTE0 = 8'h40;
  localparam logic [7:0] CMD0_BYTE1 = 8'h00;
  localparam logic [7:0] CMD0_BYTE2 = 8'h00;
  localparam logic [7:0] CMD0_BYTE3 = 8'h00;
  localparam logic [7:0] CMD0_BYTE4 = 8'h00;
  localparam logic [7:0] CMD0_BYTE5 = 8'h95;
  localparam logic [2:0] CMD0_LAST_IDX = 3'd5;

  localparam logic [7:0] R1_IDLE   = 8'h01;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/mmc_init_frame_rom.sv
// ----------------------------------------------------------------------------
// mmc_init_frame_rom
// Combinational lookup of the CMD0 frame byte at a given position.
// Ports:
//   i_index  3-bit byte position within the frame (0..5)
//   o_byte   8-bit frame byte; 0xFF for positions past the frame
// ----------------------------------------------------------------------------
module mmc_init_frame_rom
  import mmc_init_pkg::*;
(
  input  logic [2:0] i_index,
  output logic [7:0] o_byte
);

  // Positions 6 and 7 never occur in normal operation; they read as idle bytes
  always_comb begin
    o_byte = IDLE_BYTE;
    case (i_index)
      3'd0:    o_byte = CMD0_BYTE0;
      3'd1:    o_byte = CMD0_BYTE1;
      3'd2:    o_byte = CMD0_BYTE2;
      3'd3:    o_byte = CMD0_BYTE3;
      3'd4:    o_byte = CMD0_BYTE4;
      3'd5:    o_byte = CMD0_BYTE5;
      default: o_byte = IDLE_BYTE;
    endcase
  end

endmodule

// File: rtl/mmc_cmd_control_layer_init_seq.sv
// ----------------------------------------------------------------------------
// mmc_cmd_control_layer_init_seq
// SPI-mode MMC/SD power-up sequencer. Sends P_DUMMY_BYTES 0xFF clock bytes
// with CS high, then (when MMC_INIT_CMD0_EN is defined) issues CMD0 with CS
// low, polls for the R1 response, retries failed attempts up to P_RETRY
// times and finishes with one trailing 0xFF byte with CS high.
// Build option:
//   MMC_INIT_CMD0_EN  defined: full CMD0 sequence; undefined: dummy bytes only
// Ports:
//   iCLOCK, inRESET           clock, asynchronous active-low reset
//   iINIT_START               start pulse, honoured only when idle
//   oINIT_BUSY/END/ERROR      status, one-cycle done pulse, result flag
//   oMMC_REQ, iMMC_BUSY       byte request (accepted when REQ=1), layer busy
//   oMMC_CS, oMMC_DATA        chip-select level and byte to transmit
//   iMMC_VALID, iMMC_DATA     received-byte strobe and data
// ----------------------------------------------------------------------------
module mmc_cmd_control_layer_init_seq
  import mmc_init_pkg::*;
#(
  parameter int P_DUMMY_BYTES = 10,
  parameter int P_RESP_POLL   = 8,
  parameter int P_RETRY       = 3
) (
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic       iINIT_START,
  output logic       oINIT_BUSY,
  output logic       oINIT_END,
  output logic       oINIT_ERROR,
  output logic       oMMC_REQ,
  input  logic       iMMC_BUSY,
  output logic       oMMC_CS,
  output logic [7:0] oMMC_DATA,
  input  logic       iMMC_VALID,
  input  logic [7:0] iMMC_DATA
);

  localparam logic [7:0] LP_DUMMY_LAST = 8'(P_DUMMY_BYTES - 1);

  state_t     r_state;
  state_t     w_stateNext;
  logic [7:0] r_byteCnt;
  logic [7:0] w_byteCntNext;
  logic       w_accept;

`ifdef MMC_INIT_CMD0_EN
  localparam logic [7:0] LP_RESP_POLL = 8'(P_RESP_POLL);
  localparam logic [3:0] LP_RETRY     = 4'(P_RETRY);

  logic [7:0] r_pollCnt;
  logic [7:0] w_pollCntNext;
  logic [3:0] r_retryCnt;
  logic [3:0] w_retryCntNext;
  logic [2:0] r_cmdIdx;
  logic [2:0] w_cmdIdxNext;
  logic       r_trailSent;
  logic       w_trailSentNext;
  logic       r_error;
  logic       w_errorNext;
  logic [7:0] w_frameByte;

  mmc_init_frame_rom u_frameRom (
    .i_index (r_cmdIdx),
    .o_byte  (w_frameByte)
  );
`else
  logic w_unused;
  assign w_unused = &{1'b0, iMMC_VALID, iMMC_DATA, 8'(P_RESP_POLL), 4'(P_RETRY)};
`endif

  // Byte request: only the sending states ask, and only while the byte
  // layer is free. TRAIL asks once; afterwards it just waits for idle.
  always_comb begin
    oMMC_REQ = 1'b0;
    case (r_state)
      S_DUMMY:              oMMC_REQ = !iMMC_BUSY;
`ifdef MMC_INIT_CMD0_EN
      S_CMD, S_POLL_REQ:    oMMC_REQ = !iMMC_BUSY;
      S_TRAIL:              oMMC_REQ = !iMMC_BUSY && !r_trailSent;
`endif
      default:              oMMC_REQ = 1'b0;
    endcase
  end

  assign w_accept   = oMMC_REQ;
  assign oINIT_BUSY = (r_state != S_IDLE);
  assign oINIT_END  = (r_state == S_END);

`ifdef MMC_INIT_CMD0_EN
  // CS is low from the first CMD0 byte until R1 is resolved, including
  // across retries; everything else runs deselected with 0xFF on the line.
  always_comb begin
    oMMC_CS   = 1'b1;
    oMMC_DATA = IDLE_BYTE;
    case (r_state)
      S_CMD: begin
        oMMC_CS   = 1'b0;
        oMMC_DATA = w_frameByte;
      end
      S_POLL_REQ, S_POLL_WAIT: oMMC_CS = 1'b0;
      default: ;
    endcase
  end
  assign oINIT_ERROR = r_error;
`else
  assign oMMC_CS     = 1'b1;
  assign oMMC_DATA   = IDLE_BYTE;
  assign oINIT_ERROR = 1'b0;
`endif

  // Next-state and counter update. All limits are compared before the
  // increment so no counter ever wraps.
  always_comb begin
    w_stateNext   = r_state;
    w_byteCntNext = r_byteCnt;
`ifdef MMC_INIT_CMD0_EN
    w_pollCntNext   = r_pollCnt;
    w_retryCntNext  = r_retryCnt;
    w_cmdIdxNext    = r_cmdIdx;
    w_trailSentNext = r_trailSent;
    w_errorNext     = r_error;
`endif
    case (r_state)
      S_IDLE: begin
        if (iINIT_START) begin
          w_stateNext   = S_DUMMY;
          w_byteCntNext = 8'd0;
`ifdef MMC_INIT_CMD0_EN
          w_pollCntNext   = 8'd0;
          w_retryCntNext  = 4'd0;
          w_cmdIdxNext    = 3'd0;
          w_trailSentNext = 1'b0;
          w_errorNext     = 1'b0;
`endif
        end
      end
      S_DUMMY: begin
        if (w_accept) begin
          w_byteCntNext = r_byteCnt + 8'd1;
          if (r_byteCnt == LP_DUMMY_LAST) w_stateNext = S_DUMMY_WAIT;
        end
      end
      S_DUMMY_WAIT: begin
        if (!iMMC_BUSY) begin
`ifdef MMC_INIT_CMD0_EN
          w_stateNext  = S_CMD;
          w_cmdIdxNext = 3'd0;
`else
          w_stateNext  = S_END;
`endif
        end
      end
`ifdef MMC_INIT_CMD0_EN
      S_CMD: begin
        if (w_accept) begin
          if (r_cmdIdx == CMD0_LAST_IDX) begin
            w_stateNext   = S_POLL_REQ;
            w_cmdIdxNext  = 3'd0;
            w_pollCntNext = 8'd0;
          end else begin
            w_cmdIdxNext = r_cmdIdx + 3'd1;
          end
        end
      end
      S_POLL_REQ: begin
        if (w_accept) begin
          w_pollCntNext = r_pollCnt + 8'd1;
          w_stateNext   = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: begin
        if (iMMC_VALID) begin
          if (iMMC_DATA == R1_IDLE) begin
            w_stateNext     = S_TRAIL;
            w_trailSentNext = 1'b0;
          end else if ((iMMC_DATA == IDLE_BYTE) && (r_pollCnt < LP_RESP_POLL)) begin
            w_stateNext = S_POLL_REQ;
          end else if (r_retryCnt < LP_RETRY) begin
            w_retryCntNext = r_retryCnt + 4'd1;
            w_cmdIdxNext   = 3'd0;
            w_stateNext    = S_CMD;
          end else begin
            w_errorNext     = 1'b1;
            w_trailSentNext = 1'b0;
            w_stateNext     = S_TRAIL;
          end
        end
      end
      S_TRAIL: begin
        if (r_trailSent) begin
          if (!iMMC_BUSY) w_stateNext = S_END;
        end else if (w_accept) begin
          w_trailSentNext = 1'b1;
        end
      end
`endif
      S_END:   w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // State and counter registers; reset forces IDLE, which deselects the card
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state   <= S_IDLE;
      r_byteCnt <= 8'd0;
`ifdef MMC_INIT_CMD0_EN
      r_pollCnt   <= 8'd0;
      r_retryCnt  <= 4'd0;
      r_cmdIdx    <= 3'd0;
      r_trailSent <= 1'b0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_byteCnt <= w_byteCntNext;
`ifdef MMC_INIT_CMD0_EN
      r_pollCnt   <= w_pollCntNext;
      r_retryCnt  <= w_retryCntNext;
      r_cmdIdx    <= w_cmdIdxNext;
      r_trailSent <= w_trailSentNext;
      r_error     <= w_errorNext;
`endif
    end
  end

endmodule

// File: tb/tb_mmc_cmd_control_layer_init_seq.sv
// ----------------------------------------------------------------------------
// tb_mmc_cmd_control_layer_init_seq
// Drives the init sequencer through a table of card-response scenarios with a
// simple byte-layer/card model, then a reset-in-the-middle sequence.
// Honours MMC_INIT_CMD0_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_mmc_cmd_control_layer_init_seq;

  logic       iCLOCK = 1'b0;
  logic       inRESET = 1'b0;
  logic       iINIT_START = 1'b0;
  logic       iMMC_BUSY = 1'b0;
  logic       iMMC_VALID = 1'b0;
  logic [7:0] iMMC_DATA = 8'hFF;
  logic       oINIT_BUSY;
  logic       oINIT_END;
  logic       oINIT_ERROR;
  logic       oMMC_REQ;
  logic       oMMC_CS;
  logic [7:0] oMMC_DATA;

  mmc_cmd_control_layer_init_seq dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iINIT_START (iINIT_START),
    .oINIT_BUSY  (oINIT_BUSY),
    .oINIT_END   (oINIT_END),
    .oINIT_ERROR (oINIT_ERROR),
    .oMMC_REQ    (oMMC_REQ),
    .iMMC_BUSY   (iMMC_BUSY),
    .oMMC_CS     (oMMC_CS),
    .oMMC_DATA   (oMMC_DATA),
    .iMMC_VALID  (iMMC_VALID),
    .iMMC_DATA   (iMMC_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  // Scenario record: card responses in order (top byte first), expected CMD0
  // attempts and poll counts per attempt (top byte first), expected result.
  typedef struct {
    bit          rnd;
    int          nResp;
    logic [95:0] resp;
    int          nAtt;
    logic [31:0] polls;
    bit          expErr;
  } vec_t;

  // One accepted byte: CS level, data and the cycle it was accepted in
  typedef struct {
    logic       cs;
    logic [7:0] data;
    int         cyc;
  } acc_t;

  vec_t       vecs[$];
  acc_t       logQ[$];
  logic [7:0] respQ[$];
  logic [7:0] frameBytes[6];

  int   vecCount = 0;
  int   missCount = 0;
  int   cycleCount = 0;
  int   busyLeft = 0;
  bit   respPending = 0;
  bit   randomBusy = 0;
  int   endPulses = 0;
  int   endCycle = 0;
  int   reqWhileBusy = 0;
  logic endErr = 1'b0;
  int   startCycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       output bit ok);
    vecCount++;
    ok = (act === exp);
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of the byte-layer/card model. Inputs change on the falling
  // edge; outputs are sampled 1 ns later, which is what the next rising edge
  // will see. Every 0xFF byte sent with CS low gets a card response once the
  // layer's busy period ends.
  task automatic tick();
    @(negedge iCLOCK);
    cycleCount++;
    iMMC_VALID = 1'b0;
    iMMC_DATA  = 8'hFF;
    if (busyLeft > 0) begin
      iMMC_BUSY = 1'b1;
      busyLeft--;
    end else if (respPending) begin
      iMMC_BUSY   = 1'b0;
      iMMC_VALID  = 1'b1;
      iMMC_DATA   = (respQ.size() > 0) ? respQ.pop_front() : 8'hFF;
      respPending = 1'b0;
    end else begin
      iMMC_BUSY = randomBusy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    #1;
    if (oINIT_END) begin
      endPulses++;
      endErr   = oINIT_ERROR;
      endCycle = cycleCount;
    end
    if (iMMC_BUSY && oMMC_REQ) reqWhileBusy++;
    if (oMMC_REQ) begin
      logQ.push_back('{cs: oMMC_CS, data: oMMC_DATA, cyc: cycleCount});
      busyLeft    = randomBusy ? int'($urandom_range(0, 3)) : 0;
      respPending = (!oMMC_CS && oMMC_DATA == 8'hFF);
    end
  endtask

  task automatic clearModel();
    busyLeft     = 0;
    respPending  = 1'b0;
    endPulses    = 0;
    reqWhileBusy = 0;
    respQ.delete();
    logQ.delete();
  endtask

  task automatic addVec(input bit rnd, input int nResp, input logic [95:0] resp,
                        input int nAtt, input logic [31:0] polls, input bit expErr);
    vecs.push_back('{rnd: rnd, nResp: nResp, resp: resp, nAtt: nAtt, polls: polls,
                     expErr: expErr});
  endtask

  task automatic applyStimulus(input vec_t v);
    bit ok;
    int n;
    clearModel();
    for (int i = 0; i < v.nResp; i++) respQ.push_back(v.resp[95 - 8*i -: 8]);
    randomBusy  = v.rnd;
    iINIT_START = 1'b1;
    startCycle  = cycleCount;
    @(posedge iCLOCK);
    #1;
    iINIT_START = 1'b0;
    tick();
    check("errClearedOnStart", 32'(oINIT_ERROR), 32'd0, ok);
    check("busyAfterStart", 32'(oINIT_BUSY), 32'd1, ok);
    n = 0;
    while (endPulses == 0 && n < 4000) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  // Builds the expected byte stream (with cycle gaps for the busy-free case)
  // and compares it and the completion status against what was captured.
  task automatic checkOutput(input vec_t v);
    acc_t expQ[$];
    bit   ok;
    int   n;
    int   gotGap;
    int   expGap;
    for (int i = 0; i < 10; i++) expQ.push_back('{cs: 1'b1, data: 8'hFF, cyc: 1});
`ifdef MMC_INIT_CMD0_EN
    for (int a = 0; a < v.nAtt; a++) begin
      int np;
      for (int b = 0; b < 6; b++)
        expQ.push_back('{cs: 1'b0, data: frameBytes[b], cyc: (b == 0) ? 2 : 1});
      np = int'(v.polls[31 - 8*a -: 8]);
      for (int p = 0; p < np; p++)
        expQ.push_back('{cs: 1'b0, data: 8'hFF, cyc: (p == 0) ? 1 : 2});
    end
    expQ.push_back('{cs: 1'b1, data: 8'hFF, cyc: 2});
`endif
    check("byteCount", 32'(logQ.size()), 32'(expQ.size()), ok);
    n = (logQ.size() < expQ.size()) ? logQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      gotGap = logQ[i].cyc - ((i == 0) ? startCycle : logQ[i-1].cyc);
      expGap = expQ[i].cyc;
      if (v.rnd) begin
        gotGap = 0;
        expGap = 0;
      end
      check($sformatf("byte%0d{cs,data,gap}", i),
            {logQ[i].cs, logQ[i].data, 7'd0, 16'(gotGap)},
            {expQ[i].cs, expQ[i].data, 7'd0, 16'(expGap)}, ok);
      if (!ok) break;
    end
    check("endPulses", 32'(endPulses), 32'd1, ok);
    check("errorAtEnd", 32'(endErr), 32'(v.expErr), ok);
    check("errorHeld", 32'(oINIT_ERROR), 32'(v.expErr), ok);
    check("busyIdle", 32'(oINIT_BUSY), 32'd0, ok);
    check("reqWhileBusy", 32'(reqWhileBusy), 32'd0, ok);
    if (!v.rnd && logQ.size() > 0)
      check("endTiming", 32'(endCycle - logQ[logQ.size()-1].cyc), 32'd2, ok);
  endtask

  initial begin
    bit ok;
    int n;
    int stopAt;
    frameBytes = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};

`ifdef MMC_INIT_CMD0_EN
    addVec(0, 3,  {8'hFF, 8'hFF, 8'h01, 72'h0},            1, {8'd3, 24'd0},               0);
    addVec(0, 0,  96'h0,                                    4, {4{8'd8}},                   1);
    addVec(0, 2,  {8'h05, 8'h01, 80'h0},                    2, {8'd1, 8'd1, 16'd0},         0);
    addVec(1, 3,  {8'hFF, 8'hFF, 8'h01, 72'h0},            1, {8'd3, 24'd0},               0);
    addVec(0, 8,  {{7{8'hFF}}, 8'h01, 32'h0},              1, {8'd8, 24'd0},               0);
    addVec(0, 10, {{8{8'hFF}}, 8'h05, 8'h01, 16'h0},       3, {8'd8, 8'd1, 8'd1, 8'd0},    0);
    addVec(0, 4,  {{4{8'h05}}, 64'h0},                      4, {4{8'd1}},                   1);
    addVec(1, 2,  {8'h05, 8'h01, 80'h0},                    2, {8'd1, 8'd1, 16'd0},         0);
    stopAt = 13;
`else
    addVec(0, 0, 96'h0, 0, 32'd0, 0);
    addVec(1, 0, 96'h0, 0, 32'd0, 0);
    addVec(0, 0, 96'h0, 0, 32'd0, 0);
    stopAt = 5;
`endif

    // Reset values
    for (int i = 0; i < 3; i++) tick();
    check("rstReq", 32'(oMMC_REQ), 32'd0, ok);
    check("rstCs", 32'(oMMC_CS), 32'd1, ok);
    check("rstData", 32'(oMMC_DATA), 32'hFF, ok);
    check("rstBusy", 32'(oINIT_BUSY), 32'd0, ok);
    check("rstEnd", 32'(oINIT_END), 32'd0, ok);
    check("rstError", 32'(oINIT_ERROR), 32'd0, ok);
    inRESET = 1'b1;
    tick();

    foreach (vecs[k]) begin
      $display("[TB] scenario %0d", k);
      applyStimulus(vecs[k]);
      checkOutput(vecs[k]);
    end

    // Reset in the middle of the sequence (inside the CMD0 frame when enabled)
    $display("[TB] reset mid-sequence");
    clearModel();
    randomBusy  = 1'b0;
    iINIT_START = 1'b1;
    @(posedge iCLOCK);
    #1;
    iINIT_START = 1'b0;
    n = 0;
    while (logQ.size() < stopAt && n < 200) begin
      tick();
      n++;
    end
    check("midReached", 32'(logQ.size()), 32'(stopAt), ok);
`ifdef MMC_INIT_CMD0_EN
    check("csLowBeforeReset", 32'(oMMC_CS), 32'd0, ok);
`endif
    inRESET = 1'b0;
    #1;
    check("midRstCs", 32'(oMMC_CS), 32'd1, ok);
    check("midRstReq", 32'(oMMC_REQ), 32'd0, ok);
    check("midRstBusy", 32'(oINIT_BUSY), 32'd0, ok);
    check("midRstData", 32'(oMMC_DATA), 32'hFF, ok);
    tick();
    tick();
    inRESET = 1'b1;
    clearModel();
    for (int i = 0; i < 4; i++) tick();
    check("noEndAfterReset", 32'(endPulses), 32'd0, ok);
    check("idleAfterReset", 32'(oINIT_BUSY), 32'd0, ok);
    applyStimulus(vecs[0]);
    checkOutput(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
